dbus_rand_traffic_gen: RTL and testbench
========================================

Name: dbus_rand_traffic_gen

Overview:
- Synthesizable, parametrised random traffic generator and self-checker for N_CPU data-bus master ports (req/adr/dat/we/sel, ack/dat).
- Replaces per-CPU behavioural stimulus in system benches and FPGA soak tests.
- Drives the flat-packed master-side inputs of the cache-coherent system top.
- Each channel runs an independent LFSR-driven write/read stream to a private address window and checks read data against a byte-granular shadow memory.

Parameters:
- N_CPU, 4, number of independent master channels
- DBUS_AW, 32, address width
- DBUS_DW, 32, data width; must be a multiple of 32
- DBUS_ISEL, 4, byte-select width (DBUS_DW/8)
- N_SLOTS, 8, words per channel window; power of two, 2..32
- BASE_ADDR, 32'h0000_1000, start of channel 0 window
- TXN_LIMIT, 1024, transactions per channel before done
- TIMEOUT, 4096, max cycles from req assertion to ack
- SEED, 32'h0000_007B, global LFSR seed

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins traffic on all channels
- req_m2dbiu  out  N_CPU  per-channel request
- adr_m2dbiu_flat  out  N_CPU*DBUS_AW  channel i at [i*DBUS_AW +: DBUS_AW]
- dat_m2dbiu_flat  out  N_CPU*DBUS_DW  write data, same packing
- we_m2dbiu  out  N_CPU  1 = write
- sel_m2dbiu_flat  out  N_CPU*DBUS_ISEL  byte selects
- dat_dbiu2m_flat  in  N_CPU*DBUS_DW  read data
- ack_dbiu2m  in  N_CPU  transfer acknowledge
- done  out  1  all channels reached TXN_LIMIT or stopped on error
- err_mismatch  out  N_CPU  sticky read-compare failure
- err_timeout  out  N_CPU  sticky ack timeout
- err_proto  out  N_CPU  sticky ack while req low
- cycle_cnt  out  32  cycles since start, saturating

Behaviour:
- Reset: all outputs 0; channel FSMs IDLE; shadow valid bits cleared; LFSR_i = SEED ^ (i*32'h9E37_79B9), replaced by 1 if zero.
- Per-channel FSM: IDLE, DRAW, GAP, REQ, CHECK, DONE, ERR.
- IDLE: on start go to DRAW. start is ignored outside IDLE.
- DRAW (1 cycle): LFSR advances one step (Galois, taps 32,22,2,1; mask 32'h8020_0003). Fields of the new value r:
  - gap = r[1:0]
  - we = r[2]
  - slot = r[3 +: log2(N_SLOTS)]
  - sel = r[8 +: DBUS_ISEL], all-ones if zero; reads always use all-ones
  - wdata = r replicated DBUS_DW/32 times
  - adr = BASE_ADDR + (i*N_SLOTS + slot)*(DBUS_DW/8)
- GAP: wait gap cycles (0..3), then REQ.
- REQ:
  - req high; adr/dat/we/sel stable until ack sampled high; timeout counter runs.
  - On ack: req deasserts the next cycle. Reads capture dat_dbiu2m; writes merge selected bytes into shadow[slot] and set their valid bits. Then CHECK.
  - Timeout counter reaching TIMEOUT sets err_timeout[i] and goes to ERR.
- CHECK (1 cycle):
  - Reads: compare only bytes whose shadow valid bit is set; any difference sets err_mismatch[i] and goes to ERR.
  - Then txn_cnt increments. If txn_cnt == TXN_LIMIT go to DONE, else DRAW.
- Minimum 4 cycles per transaction (DRAW, REQ, ack, CHECK).
- ERR, DONE: req low; terminal until reset.
- done = all channels in DONE or ERR.
- cycle_cnt: starts counting on start; freezes when done rises; saturates at 32'hFFFF_FFFF.
- ack while req low (including the cycle after ack): sets err_proto[i] only; no state change.
- Ack in the same cycle req first rises is legal (zero-wait responder).
- Asynchronous reset mid-transaction: req drops immediately, shadow invalidated, channel returns to IDLE and needs a new start.
- Channels are fully independent; simultaneous acks on all channels are handled in the same cycle.

Test Plan:
- N_CPU=2, TXN_LIMIT=16, ideal memory model acking after 2 cycles, start pulse -> no error bits set, done high. Channel 0 addresses only in 0x1000..0x101C, channel 1 only in 0x1020..0x103C. Identical run repeated -> identical address/data trace.
- Memory model corrupts bit 0 of the first read data for a slot previously written by channel 1 -> err_mismatch=2'b10 in the CHECK cycle. Channel 0 completes; done rises once channel 0 reaches DONE.
- Responder never acks channel 0 -> err_timeout[0] set exactly TIMEOUT cycles after req rise; channel 1 unaffected.
- Zero-wait responder (ack combinational on req) -> every transaction takes exactly gap+4 cycles; cycle_cnt at done equals the sum checked by the bench.
- Ack pulse injected while req low on channel 1 -> err_proto=2'b10; traffic continues; no mismatch.
- Assert resetn=0 mid-REQ -> req drops in the same cycle and all outputs read 0. Release and restart -> LFSR sequence repeats from the first transaction.

Source files
------------

// File: rtl/dbus_rand_traffic_gen.sv
// Random data-bus traffic generator with per-channel byte-granular shadow checking.
// Each channel walks an LFSR-driven write/read stream over its own private address window.
module dbus_rand_traffic_gen #(
    parameter int                 N_CPU     = 4,
    parameter int                 DBUS_AW   = 32,
    parameter int                 DBUS_DW   = 32,
    parameter int                 DBUS_ISEL = 4,
    parameter int                 N_SLOTS   = 8,
    parameter logic [DBUS_AW-1:0] BASE_ADDR = 32'h0000_1000,
    parameter int                 TXN_LIMIT = 1024,
    parameter int                 TIMEOUT   = 4096,
    parameter logic [31:0]        SEED      = 32'h0000_007B
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    output logic [N_CPU-1:0]             req_m2dbiu,
    output logic [N_CPU*DBUS_AW-1:0]     adr_m2dbiu_flat,
    output logic [N_CPU*DBUS_DW-1:0]     dat_m2dbiu_flat,
    output logic [N_CPU-1:0]             we_m2dbiu,
    output logic [N_CPU*DBUS_ISEL-1:0]   sel_m2dbiu_flat,
    input  logic [N_CPU*DBUS_DW-1:0]     dat_dbiu2m_flat,
    input  logic [N_CPU-1:0]             ack_dbiu2m,
    output logic                         done,
    output logic [N_CPU-1:0]             err_mismatch,
    output logic [N_CPU-1:0]             err_timeout,
    output logic [N_CPU-1:0]             err_proto,
    output logic [31:0]                  cycle_cnt
);

    localparam int          SW        = $clog2(N_SLOTS);
    localparam int          REP       = DBUS_DW / 32;
    localparam int          BPW       = DBUS_DW / 8;
    localparam int          TW        = $clog2(TXN_LIMIT + 1);
    localparam int          OW        = $clog2(TIMEOUT + 1);
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAW, S_GAP, S_REQ, S_CHECK, S_DONE, S_ERR
    } state_t;

    logic [N_CPU-1:0] term;
    logic             running_q;

    for (genvar i = 0; i < N_CPU; i++) begin : g_ch
        localparam logic [31:0] SEED_MIX = SEED ^ (32'(i) * 32'h9E37_79B9);
        localparam logic [31:0] SEED_I   = (SEED_MIX == 32'd0) ? 32'd1 : SEED_MIX;

        state_t               state_q, state_d;
        logic [31:0]          lfsr_q, lfsr_nxt;
        logic [1:0]           gap_q;
        logic                 we_q, acked_q;
        logic [SW-1:0]        slot_q;
        logic [DBUS_ISEL-1:0] sel_q, sel_draw;
        logic [DBUS_DW-1:0]   wdata_q, rdata_q, rdat;
        logic [DBUS_AW-1:0]   adr_q;
        logic [OW-1:0]        tmo_q;
        logic [TW-1:0]        txn_q;
        logic [DBUS_DW-1:0]   shadow_dat [N_SLOTS];
        logic [DBUS_ISEL-1:0] shadow_vld [N_SLOTS];
        logic                 ack, req, fin, tmo_hit, last_txn, miscmp;
        logic                 mism_q, tmo_err_q, proto_q;

        assign ack      = ack_dbiu2m[i];
        assign rdat     = dat_dbiu2m_flat[i*DBUS_DW +: DBUS_DW];
        assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
        assign sel_draw = (!lfsr_nxt[2] || lfsr_nxt[8 +: DBUS_ISEL] == '0) ? '1
                                                                           : lfsr_nxt[8 +: DBUS_ISEL];
        assign tmo_hit  = (tmo_q == OW'(TIMEOUT - 1));
        assign last_txn = (txn_q == TW'(TXN_LIMIT - 1));

        // Only bytes this run has written are trusted; everything else is don't-care.
        always_comb begin
            miscmp = 1'b0;
            for (int b = 0; b < DBUS_ISEL; b++) begin
                if (!we_q && shadow_vld[slot_q][b] &&
                    rdata_q[8*b +: 8] != shadow_dat[slot_q][8*b +: 8]) begin
                    miscmp = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) state_q <= S_IDLE;
            else         state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                S_IDLE:  if (start) state_d = S_DRAW;
                S_DRAW:  state_d = (lfsr_nxt[1:0] == 2'd0) ? S_REQ : S_GAP;
                S_GAP:   if (gap_q == 2'd1) state_d = S_REQ;
                S_REQ: begin
                    if (acked_q)              state_d = S_CHECK;
                    else if (!ack && tmo_hit) state_d = S_ERR;
                end
                S_CHECK: begin
                    if (miscmp)        state_d = S_ERR;
                    else if (last_txn) state_d = S_DONE;
                    else               state_d = S_DRAW;
                end
                default: state_d = state_q;
            endcase
        end

        // req falls in the cycle after the ack edge, while the FSM is still in REQ.
        always_comb begin
            req = (state_q == S_REQ) && !acked_q;
            fin = (state_q == S_DONE) || (state_q == S_ERR);
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                lfsr_q  <= SEED_I;
                gap_q   <= '0;
                we_q    <= 1'b0;
                acked_q <= 1'b0;
                slot_q  <= '0;
                sel_q   <= '0;
                wdata_q <= '0;
                rdata_q <= '0;
                adr_q   <= '0;
                tmo_q   <= '0;
                txn_q   <= '0;
                for (int s = 0; s < N_SLOTS; s++) begin
                    shadow_dat[s] <= '0;
                    shadow_vld[s] <= '0;
                end
            end else begin
                case (state_q)
                    S_DRAW: begin
                        lfsr_q  <= lfsr_nxt;
                        gap_q   <= lfsr_nxt[1:0];
                        we_q    <= lfsr_nxt[2];
                        slot_q  <= lfsr_nxt[3 +: SW];
                        sel_q   <= sel_draw;
                        wdata_q <= {REP{lfsr_nxt}};
                        adr_q   <= BASE_ADDR +
                                   DBUS_AW'((i * N_SLOTS + int'(lfsr_nxt[3 +: SW])) * BPW);
                        acked_q <= 1'b0;
                        tmo_q   <= '0;
                    end
                    S_GAP: gap_q <= gap_q - 2'd1;
                    S_REQ: begin
                        if (!acked_q) begin
                            if (ack) begin
                                acked_q <= 1'b1;
                                if (we_q) begin
                                    for (int b = 0; b < DBUS_ISEL; b++) begin
                                        if (sel_q[b]) begin
                                            shadow_dat[slot_q][8*b +: 8] <= wdata_q[8*b +: 8];
                                            shadow_vld[slot_q][b]        <= 1'b1;
                                        end
                                    end
                                end else begin
                                    rdata_q <= rdat;
                                end
                            end else begin
                                tmo_q <= tmo_q + OW'(1);
                            end
                        end
                    end
                    S_CHECK: txn_q <= txn_q + TW'(1);
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                mism_q    <= 1'b0;
                tmo_err_q <= 1'b0;
                proto_q   <= 1'b0;
            end else begin
                if (state_q == S_CHECK && miscmp)                     mism_q    <= 1'b1;
                if (state_q == S_REQ && !acked_q && !ack && tmo_hit) tmo_err_q <= 1'b1;
                if (ack && !req)                                      proto_q   <= 1'b1;
            end
        end

        assign req_m2dbiu[i]                          = req;
        assign we_m2dbiu[i]                           = we_q;
        assign adr_m2dbiu_flat[i*DBUS_AW +: DBUS_AW]  = adr_q;
        assign dat_m2dbiu_flat[i*DBUS_DW +: DBUS_DW]  = wdata_q;
        assign sel_m2dbiu_flat[i*DBUS_ISEL +: DBUS_ISEL] = sel_q;
        assign err_mismatch[i]                        = mism_q;
        assign err_timeout[i]                         = tmo_err_q;
        assign err_proto[i]                           = proto_q;
        assign term[i]                                = fin;
    end

    assign done = &term;

    // Counts every cycle after the start edge until done; frozen from then on.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            running_q <= 1'b0;
            cycle_cnt <= '0;
        end else if (!running_q) begin
            if (start) begin
                running_q <= 1'b1;
                cycle_cnt <= '0;
            end
        end else if (!done && cycle_cnt != 32'hFFFF_FFFF) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_dbus_rand_traffic_gen.sv
// Bench for dbus_rand_traffic_gen: two channels, behavioural responder/memory,
// transaction scoreboard fed by an LFSR-level reference model.
module tb_dbus_rand_traffic_gen;

    localparam int          NC   = 2;
    localparam int          TXN  = 16;
    localparam int          TMO  = 64;
    localparam logic [31:0] SEED = 32'h0000_007B;
    localparam int          W    = 69;  // {adr, we, sel, dat}

    logic          clk = 1'b0;
    logic          resetn, start;
    logic [1:0]    req_m2dbiu, we_m2dbiu, ack_dbiu2m;
    logic [63:0]   adr_flat, dat_out_flat, dat_in;
    logic [7:0]    sel_flat;
    logic          done;
    logic [1:0]    err_mismatch, err_timeout, err_proto;
    logic [31:0]   cycle_cnt;

    int            n_vec = 0, n_err = 0, cyc = 0;
    logic [W-1:0]  exp_q [NC][$];
    int            hs_cnt [NC];
    logic [31:0]   sig [NC];
    logic [7:0]    mem [64];
    int            wcnt [NC], lat [NC];
    logic [1:0]    ack_drv, never_ack;
    logic          zw_mode, inj_armed, corrupt_on;
    int            fixed_lat, corrupt_k;

    dbus_rand_traffic_gen #(
        .N_CPU(NC), .DBUS_AW(32), .DBUS_DW(32), .DBUS_ISEL(4), .N_SLOTS(8),
        .BASE_ADDR(32'h0000_1000), .TXN_LIMIT(TXN), .TIMEOUT(TMO), .SEED(SEED)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .req_m2dbiu(req_m2dbiu), .adr_m2dbiu_flat(adr_flat), .dat_m2dbiu_flat(dat_out_flat),
        .we_m2dbiu(we_m2dbiu), .sel_m2dbiu_flat(sel_flat), .dat_dbiu2m_flat(dat_in),
        .ack_dbiu2m(ack_dbiu2m), .done(done), .err_mismatch(err_mismatch),
        .err_timeout(err_timeout), .err_proto(err_proto), .cycle_cnt(cycle_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ack_dbiu2m = zw_mode ? req_m2dbiu : ack_drv;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] r);
        return r[0] ? ((r >> 1) ^ 32'h8020_0003) : (r >> 1);
    endfunction

    // Reference: walk the channel's LFSR stream and derive each transaction from its fields.
    task automatic model_chan(input int ch, output int cyc_sum, output int corrupt_at);
        logic [31:0] r, adr;
        logic [3:0]  sel;
        logic [3:0]  vld [8];
        int          slot, gap;
        logic        we;
        r = SEED ^ (32'(ch) * 32'h9E37_79B9);
        if (r == 32'd0) r = 32'd1;
        for (int s = 0; s < 8; s++) vld[s] = 4'h0;
        cyc_sum = 0;
        corrupt_at = -1;
        for (int k = 0; k < TXN; k++) begin
            r    = lfsr_step(r);
            gap  = int'(r[1:0]);
            we   = r[2];
            slot = int'(r[5:3]);
            sel  = r[11:8];
            if (!we || sel == 4'h0) sel = 4'hF;
            adr  = 32'h1000 + 32'((ch * 8 + slot) * 4);
            cyc_sum += gap + 4;
            if (!we && corrupt_at < 0 && vld[slot][0]) corrupt_at = k;
            if (we) vld[slot] = vld[slot] | sel;
            exp_q[ch].push_back({adr, we, sel, we ? r : 32'h0});
        end
    endtask

    // ---------------- responder + memory ----------------
    always @(negedge clk) begin
        logic [31:0] a, d;
        int idx;
        for (int i = 0; i < NC; i++) begin
            ack_drv[i] = 1'b0;
            if (req_m2dbiu[i]) begin
                if (wcnt[i] == 0) lat[i] = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                wcnt[i]++;
                if (!never_ack[i] && wcnt[i] == lat[i] + 1) ack_drv[i] = 1'b1;
            end else begin
                wcnt[i] = 0;
            end
            a = adr_flat[i*32 +: 32];
            d = 32'h0;
            if (a >= 32'h1000 && a < 32'h1040) begin
                idx = int'(a - 32'h1000);
                d = {mem[idx+3], mem[idx+2], mem[idx+1], mem[idx]};
            end
            if (corrupt_on && i == 1 && hs_cnt[1] == corrupt_k && !we_m2dbiu[1]) d[0] = ~d[0];
            dat_in[i*32 +: 32] = d;
        end
        if (inj_armed && hs_cnt[1] >= 5 && !req_m2dbiu[1]) begin
            ack_drv[1] = 1'b1;
            inj_armed  = 1'b0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0]  got, e;
        logic [31:0]   a, d, lo;
        logic [3:0]    s;
        logic          w;
        int            idx;
        #1;
        for (int i = 0; i < NC; i++) begin
            if (resetn && req_m2dbiu[i] && ack_dbiu2m[i]) begin
                a   = adr_flat[i*32 +: 32];
                d   = dat_out_flat[i*32 +: 32];
                s   = sel_flat[i*4 +: 4];
                w   = we_m2dbiu[i];
                got = {a, w, s, w ? d : 32'h0};
                if (exp_q[i].size() == 0) begin
                    check($sformatf("unexpected_txn_ch%0d", i), got, '0);
                end else begin
                    e = exp_q[i].pop_front();
                    check($sformatf("txn_ch%0d_%0d", i, hs_cnt[i]), got, e);
                end
                lo = 32'h1000 + 32'(i * 32);
                check($sformatf("adr_window_ch%0d", i),
                      (a >= lo && a <= lo + 32'd28 && a[1:0] == 2'b00), 1);
                if (w && a >= 32'h1000 && a < 32'h1040) begin
                    idx = int'(a - 32'h1000);
                    for (int b = 0; b < 4; b++) if (s[b]) mem[idx+b] = d[8*b +: 8];
                end
                sig[i] = {sig[i][30:0], sig[i][31]} ^ a ^ d;
                hs_cnt[i]++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic prep();
        for (int i = 0; i < NC; i++) begin
            exp_q[i].delete();
            hs_cnt[i] = 0;
            sig[i]    = 32'h0;
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic fire_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL done_wait: done=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req"},  req_m2dbiu, 0);
        check({tag, "_adr"},  adr_flat, 0);
        check({tag, "_dat"},  dat_out_flat, 0);
        check({tag, "_we"},   we_m2dbiu, 0);
        check({tag, "_sel"},  sel_flat, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_errs"}, {err_mismatch, err_timeout, err_proto}, 0);
        check({tag, "_cyc"},  cycle_cnt, 0);
    endtask

    task automatic check_end(input string tag, input logic [1:0] em, input logic [1:0] et,
                             input logic [1:0] ep, input logic [1:0] qmask);
        check({tag, "_done"},     done, 1);
        check({tag, "_mismatch"}, err_mismatch, em);
        check({tag, "_timeout"},  err_timeout, et);
        check({tag, "_proto"},    err_proto, ep);
        for (int i = 0; i < NC; i++)
            if (qmask[i]) check($sformatf("%s_left_ch%0d", tag, i), exp_q[i].size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cs0, cs1, ck0, ck1, t0, t1, k;
        logic [31:0] sig_a [NC];
        logic [31:0] cc;
        resetn = 1'b0; start = 1'b0; zw_mode = 1'b0; fixed_lat = 2;
        never_ack = 2'b00; inj_armed = 1'b0; corrupt_on = 1'b0; corrupt_k = -1;
        ack_drv = 2'b00; dat_in = '0;
        for (int i = 0; i < NC; i++) begin wcnt[i] = 0; lat[i] = 0; end
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
        prep();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);

        // Ideal memory, fixed 2-cycle ack
        prep(); model_chan(0, cs0, ck0); model_chan(1, cs1, ck1);
        fire_start(); wait_done(3000);
        check_end("ideal", 2'b00, 2'b00, 2'b00, 2'b11);
        check("ideal_hs0", hs_cnt[0], TXN);
        check("ideal_hs1", hs_cnt[1], TXN);
        for (int i = 0; i < NC; i++) sig_a[i] = sig[i];

        // Same run, random ack latency: trace must repeat
        apply_reset(); prep(); fixed_lat = -1;
        model_chan(0, cs0, ck0); model_chan(1, cs1, ck1);
        fire_start(); wait_done(3000);
        check_end("repeat", 2'b00, 2'b00, 2'b00, 2'b11);
        for (int i = 0; i < NC; i++) check($sformatf("trace_sig_ch%0d", i), sig[i], sig_a[i]);

        // Corrupt first read of a written byte 0 on channel 1
        apply_reset(); prep();
        model_chan(0, cs0, ck0); model_chan(1, cs1, ck1);
        check("corrupt_target_found", ck1 >= 0, 1);
        if (ck1 >= 0) while (exp_q[1].size() > ck1 + 1) void'(exp_q[1].pop_back());
        corrupt_k = ck1; corrupt_on = 1'b1;
        fire_start(); wait_done(3000);
        check_end("mismatch", 2'b10, 2'b00, 2'b00, 2'b11);
        corrupt_on = 1'b0;

        // Channel 0 never acknowledged
        apply_reset(); prep(); never_ack = 2'b01;
        model_chan(0, cs0, ck0); model_chan(1, cs1, ck1);
        fire_start();
        k = 0;
        while (!req_m2dbiu[0] && k < 50) begin @(negedge clk); #2; k++; end
        t0 = cyc;
        k = 0;
        while (!err_timeout[0] && k < 4 * TMO) begin @(negedge clk); #2; k++; end
        t1 = cyc;
        check("timeout_latency", t1 - t0, TMO);
        wait_done(3000);
        check_end("timeout", 2'b00, 2'b01, 2'b00, 2'b10);
        check("timeout_hs0", hs_cnt[0], 0);
        never_ack = 2'b00;

        // Zero-wait responder: each transaction costs gap+4 cycles
        apply_reset(); prep(); zw_mode = 1'b1;
        model_chan(0, cs0, ck0); model_chan(1, cs1, ck1);
        fire_start(); wait_done(3000);
        check("zw_cycle_cnt", cycle_cnt, (cs0 > cs1) ? cs0 : cs1);
        check_end("zw", 2'b00, 2'b00, 2'b00, 2'b11);
        cc = cycle_cnt;
        repeat (4) @(negedge clk);
        check("zw_cycle_frozen", cycle_cnt, cc);
        zw_mode = 1'b0;

        // Stray ack on channel 1 while req is low
        apply_reset(); prep(); inj_armed = 1'b1;
        model_chan(0, cs0, ck0); model_chan(1, cs1, ck1);
        fire_start(); wait_done(3000);
        check_end("proto", 2'b00, 2'b00, 2'b10, 2'b11);
        inj_armed = 1'b0;

        // Reset mid-REQ, then restart from the first transaction
        apply_reset(); prep();
        model_chan(0, cs0, ck0); model_chan(1, cs1, ck1);
        fire_start();
        k = 0;
        while (!(hs_cnt[0] >= 3 && req_m2dbiu[0]) && k < 500) begin @(negedge clk); #2; k++; end
        check("midreq_reached", req_m2dbiu[0], 1);
        resetn = 1'b0;
        #1;
        check_zero_outputs("midreq");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        prep(); model_chan(0, cs0, ck0); model_chan(1, cs1, ck1);
        fire_start(); wait_done(3000);
        check_end("restart", 2'b00, 2'b00, 2'b00, 2'b11);
        check("restart_hs0", hs_cnt[0], TXN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
